dense_mac_layer1: RTL and testbench



---
 rtl/dense_mac_layer1.sv | 129 ++++++++++++
 tb/tb_dense_mac_layer1.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dense_mac_layer1.sv
// Layer-1 dense evaluation: OUT_SIZE parallel signed MACs walk the activation
// vector one index per clock, then scale, optionally ReLU and saturate to W bits.
module dense_mac_layer1 #(
    parameter int IN_SIZE   = 1152,
    parameter int OUT_SIZE  = 8,
    parameter int W         = 8,
    parameter int ACC_W     = 32,
    parameter int SHIFT     = 7,
    parameter int RELU      = 1,
    parameter int IDX_WIDTH = 11
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           weights_valid,
    input  logic [IN_SIZE*OUT_SIZE*W-1:0]  weights_in,
    input  logic [IN_SIZE*W-1:0]           act_in,
    output logic [OUT_SIZE*W-1:0]          data_out,
    output logic                           done
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT_W = 3'd1;
    localparam logic [2:0] ST_ACC    = 3'd2;
    localparam logic [2:0] ST_POST   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(IN_SIZE - 1);
    localparam logic                 RELU_EN  = (RELU != 0);
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    logic [2:0]                 state_r;
    logic [IDX_WIDTH-1:0]       idx_r;
    logic signed [ACC_W-1:0]    acc_r  [OUT_SIZE];
    logic signed [ACC_W-1:0]    term_s [OUT_SIZE];
    logic [W-1:0]               act_s;

    // Signed W x W product, sign-extended to the accumulator width.
    function automatic logic signed [ACC_W-1:0] mac_term(input logic [W-1:0] a,
                                                         input logic [W-1:0] w);
        logic signed [2*W-1:0] a_x;
        logic signed [2*W-1:0] w_x;
        logic signed [2*W-1:0] p;
        a_x = {{W{a[W-1]}}, a};
        w_x = {{W{w[W-1]}}, w};
        p   = a_x * w_x;
        return {{(ACC_W-2*W){p[2*W-1]}}, p};
    endfunction

    // Arithmetic shift, optional ReLU, then clamp into the signed W-bit range.
    function automatic logic [W-1:0] post_scale(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] v;
        v = acc >>> SHIFT;
        if (RELU_EN && v[ACC_W-1]) begin
            v = {ACC_W{1'b0}};
        end
        if (v > SAT_HI) begin
            return SAT_HI[W-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[W-1:0];
        end else begin
            return v[W-1:0];
        end
    endfunction

    // Per-neuron product for the current input index.
    always_comb begin
        act_s = act_in[int'(idx_r)*W +: W];
        for (int o = 0; o < OUT_SIZE; o++) begin
            term_s[o] = mac_term(act_s, weights_in[(o*IN_SIZE + int'(idx_r))*W +: W]);
        end
    end

    // Control FSM, accumulators and published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            idx_r    <= {IDX_WIDTH{1'b0}};
            data_out <= {(OUT_SIZE*W){1'b0}};
            done     <= 1'b0;
            for (int o = 0; o < OUT_SIZE; o++) acc_r[o] <= {ACC_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_WAIT_W: begin
                    if (state_r == ST_WAIT_W && !start) begin
                        state_r <= ST_IDLE;
                    end else if (start && weights_valid) begin
                        state_r <= ST_ACC;
                        idx_r   <= {IDX_WIDTH{1'b0}};
                        for (int o = 0; o < OUT_SIZE; o++) acc_r[o] <= {ACC_W{1'b0}};
                    end else if (start) begin
                        state_r <= ST_WAIT_W;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACC: begin
                    for (int o = 0; o < OUT_SIZE; o++) acc_r[o] <= acc_r[o] + term_s[o];
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_POST;
                        idx_r   <= {IDX_WIDTH{1'b0}};
                    end else begin
                        idx_r   <= idx_r + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_POST: begin
                    for (int o = 0; o < OUT_SIZE; o++) data_out[o*W +: W] <= post_scale(acc_r[o]);
                    done    <= 1'b1;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    // A held start must not retrigger; only a low start releases DONE.
                    if (!start) begin
                        state_r <= ST_IDLE;
                        done    <= 1'b0;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_mac_layer1.sv
// Directed bench for dense_mac_layer1: three parameterisations (small linear,
// small ReLU/shift, full default size with a behavioural reference).
module tb_dense_mac_layer1;

    logic clk = 1'b0;
    logic rst;
    logic start_v [3];
    logic valid_v [3];
    logic done_v  [3];

    logic [63:0]        weights_a;
    logic [31:0]        act_a;
    logic [15:0]        data_a;
    logic [63:0]        weights_b;
    logic [31:0]        act_b;
    logic [15:0]        data_b;
    logic [1152*8*8-1:0] weights_c;
    logic [1152*8-1:0]   act_c;
    logic [63:0]         data_c;
    logic [63:0]         exp_c;

    int ac [1152];
    int wc [8][1152];
    int n_cmp  = 0;
    int n_fail = 0;
    int n;

    always #5 clk = ~clk;

    dense_mac_layer1 #(.IN_SIZE(4), .OUT_SIZE(2), .W(8), .ACC_W(32), .SHIFT(0), .RELU(0), .IDX_WIDTH(3))
    u_dut_a (.clk(clk), .rst(rst), .start(start_v[0]), .weights_valid(valid_v[0]),
             .weights_in(weights_a), .act_in(act_a), .data_out(data_a), .done(done_v[0]));

    dense_mac_layer1 #(.IN_SIZE(4), .OUT_SIZE(2), .W(8), .ACC_W(32), .SHIFT(2), .RELU(1), .IDX_WIDTH(3))
    u_dut_b (.clk(clk), .rst(rst), .start(start_v[1]), .weights_valid(valid_v[1]),
             .weights_in(weights_b), .act_in(act_b), .data_out(data_b), .done(done_v[1]));

    dense_mac_layer1 u_dut_c (.clk(clk), .rst(rst), .start(start_v[2]), .weights_valid(valid_v[2]),
             .weights_in(weights_c), .act_in(act_c), .data_out(data_c), .done(done_v[2]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts rising edges (sampled at the following falling edge) until done is seen.
    task automatic wait_done(input int k, input int budget, output int edges);
        edges = 0;
        while (edges < budget) begin
            @(negedge clk);
            edges++;
            if (done_v[k] === 1'b1) return;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            valid_v[k] = 1'b0;
        end
        weights_a = 64'h0; act_a = 32'h0;
        weights_b = 64'h0; act_b = 32'h0;
        weights_c = '0;    act_c = '0;
        repeat (3) @(negedge clk);
        check("rst_done_a", 64'(done_v[0]), 64'h0);
        check("rst_data_a", 64'(data_a), 64'h0);
        check("rst_done_b", 64'(done_v[1]), 64'h0);
        check("rst_data_b", 64'(data_b), 64'h0);
        check("rst_done_c", 64'(done_v[2]), 64'h0);
        check("rst_data_c", data_c, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // act={1,2,3,4}, w0 all 1 -> 10, w1 all -1 -> -10
        act_a = 32'h04030201;
        weights_a = {32'hFFFFFFFF, 32'h01010101};
        valid_v[0] = 1'b1; start_v[0] = 1'b1;
        wait_done(0, 20, n);
        check("lin_latency", 64'(n), 64'd6);
        check("lin_data", 64'(data_a), 64'hF60A);
        start_v[0] = 1'b0;
        @(negedge clk);
        check("lin_done_clr", 64'(done_v[0]), 64'h0);

        // Saturation: 4*127*127 -> 127, 4*127*-128 -> -128
        act_a = 32'h7F7F7F7F;
        weights_a = {32'h80808080, 32'h7F7F7F7F};
        start_v[0] = 1'b1;
        wait_done(0, 20, n);
        check("sat_latency", 64'(n), 64'd6);
        check("sat_data", 64'(data_a), 64'h807F);
        start_v[0] = 1'b0;
        @(negedge clk);

        // ReLU + shift 2: acc0=-40 -> 0, acc1=37 -> 9
        act_b = 32'h01010101;
        weights_b = {32'h070A0A0A, 32'hF6F6F6F6};
        valid_v[1] = 1'b1; start_v[1] = 1'b1;
        wait_done(1, 20, n);
        check("relu_latency", 64'(n), 64'd6);
        check("relu_data", 64'(data_b), 64'h0900);
        start_v[1] = 1'b0;
        @(negedge clk);

        // Handshake: start without weights, then weights arrive. Expect w0 -> -10, w1 -> 20.
        valid_v[0] = 1'b0;
        act_a = 32'h04FD02FF;
        weights_a = {32'h0A0A0A0A, 32'h0001FE03};
        start_v[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("wait_no_done", 64'(done_v[0]), 64'h0);
        check("wait_data_held", 64'(data_a), 64'h807F);
        valid_v[0] = 1'b1;
        wait_done(0, 20, n);
        check("hs_latency", 64'(n), 64'd6);
        check("hs_data", 64'(data_a), 64'h14F6);
        repeat (10) @(negedge clk);
        check("hold_done", 64'(done_v[0]), 64'h1);
        check("hold_data", 64'(data_a), 64'h14F6);
        start_v[0] = 1'b0;
        @(negedge clk);
        check("drop_done", 64'(done_v[0]), 64'h0);
        check("drop_data", 64'(data_a), 64'h14F6);

        // Reset at idx=2, then a clean rerun.
        act_a = 32'h04030201;
        weights_a = {32'hFFFFFFFF, 32'h01010101};
        start_v[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1; start_v[0] = 1'b0;
        @(negedge clk);
        check("mid_rst_done", 64'(done_v[0]), 64'h0);
        check("mid_rst_data", 64'(data_a), 64'h0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_rst_idle", 64'(done_v[0]), 64'h0);
        start_v[0] = 1'b1;
        wait_done(0, 20, n);
        check("rerun_latency", 64'(n), 64'd6);
        check("rerun_data", 64'(data_a), 64'hF60A);
        start_v[0] = 1'b0;
        @(negedge clk);

        // Full-size run: neurons 0-3 small-range weights, 4-7 full-range.
        for (int i = 0; i < 1152; i++) begin
            ac[i] = int'($urandom_range(15, 0)) - 8;
            act_c[i*8 +: 8] = 8'(ac[i]);
            for (int o = 0; o < 8; o++) begin
                wc[o][i] = (o < 4) ? int'($urandom_range(15, 0)) - 8 : int'($urandom_range(255, 0)) - 128;
                weights_c[(o*1152 + i)*8 +: 8] = 8'(wc[o][i]);
            end
        end
        for (int o = 0; o < 8; o++) begin
            int s;
            int v;
            s = 0;
            for (int i = 0; i < 1152; i++) s += ac[i] * wc[o][i];
            v = s >>> 7;
            if (v < 0) v = 0;
            if (v > 127) v = 127;
            exp_c[o*8 +: 8] = 8'(v);
        end
        valid_v[2] = 1'b1; start_v[2] = 1'b1;
        wait_done(2, 2000, n);
        check("full_latency", 64'(n), 64'd1154);
        check("full_data", data_c, exp_c);
        start_v[2] = 1'b0;
        @(negedge clk);
        check("full_done_clr", 64'(done_v[2]), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
